// File: rtl/myrisc16_pkg.sv
// Shared definitions for the myrisc16 core: states, opcodes, instruction
// field positions and small decode helpers.
package myrisc16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RA_MSB    = 12;
    localparam int RA_LSB    = 10;
    localparam int RB_MSB    = 9;
    localparam int RB_LSB    = 7;
    localparam int RC_MSB    = 2;
    localparam int RC_LSB    = 0;
    localparam int IMM7_MSB  = 6;
    localparam int IMM10_MSB = 9;

    function automatic logic [2:0] get_op(input logic [15:0] inst);
        return inst[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] get_ra(input logic [15:0] inst);
        return inst[RA_MSB:RA_LSB];
    endfunction

    function automatic logic [2:0] get_rb(input logic [15:0] inst);
        return inst[RB_MSB:RB_LSB];
    endfunction

    function automatic logic [2:0] get_rc(input logic [15:0] inst);
        return inst[RC_MSB:RC_LSB];
    endfunction

    // Sign-extended 7-bit immediate used by ADDI, SW, LW and BEQ.
    function automatic logic [15:0] get_simm7(input logic [15:0] inst);
        return {{9{inst[IMM7_MSB]}}, inst[IMM7_MSB:0]};
    endfunction

    // Upper-immediate value placed by LUI.
    function automatic logic [15:0] get_lui(input logic [15:0] inst);
        return {inst[IMM10_MSB:0], 6'b0};
    endfunction

    // Opcode 7 is JALR only when the low seven bits are zero; anything else halts.
    function automatic logic is_halt(input logic [15:0] inst);
        return (get_op(inst) == OP_JALR) && (inst[IMM7_MSB:0] != 7'd0);
    endfunction

endpackage

// File: rtl/myrisc16_regfile.sv
// Eight 16-bit registers with r0 hardwired to zero, two asynchronous read
// ports, one synchronous write port and a bulk clear used when a run starts.
module myrisc16_regfile
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [2:0]  rd_addr_a,
    input  logic [2:0]  rd_addr_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data
);

    logic [15:0] regs [0:7];

    // Register storage: reset and run-start clear everything, writes to r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != 3'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 3'd0) ? 16'd0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 3'd0) ? 16'd0 : regs[rd_addr_b];

endmodule

// File: rtl/myrisc16_core.sv
// Two-cycle 16-bit teaching CPU with a loadable unified memory, run/halt
// control, a store-mapped LED register and a retired-instruction counter.
module myrisc16_core
    import myrisc16_pkg::*;
#(
    parameter int MEM_AW   = 4,
    parameter int LED_W    = 8,
    parameter int LED_ADDR = 2**MEM_AW - 1
)
(
    input  logic              in_clock,
    input  logic              in_reset_n,
    input  logic              in_run,
    input  logic              in_load_valid,
    input  logic [MEM_AW-1:0] in_load_addr,
    input  logic [15:0]       in_load_data,
    output logic              out_load_ready,
    output logic              out_halted,
    output logic [LED_W-1:0]  out_led,
    output logic [15:0]       out_pc,
    output logic [15:0]       out_retired
);

    localparam int                DEPTH   = 2**MEM_AW;
    localparam logic [MEM_AW-1:0] LED_IDX = MEM_AW'(LED_ADDR);

    state_t state;
    state_t state_next;

    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] retired;
    logic [15:0] mem [0:DEPTH-1];

    logic [2:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  sec_addr;
    logic [15:0] imm_s;
    logic [15:0] rb_val;
    logic [15:0] sec_val;
    logic [MEM_AW-1:0] mem_idx;

    logic        exec;
    logic        start;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic        mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [15:0] mem_wdata;

    assign op      = get_op(inst);
    assign ra      = get_ra(inst);
    assign rb      = get_rb(inst);
    assign imm_s   = get_simm7(inst);
    assign exec    = (state == ST_EXEC);

    // ADD and NAND read rb/rc; every other instruction reads rb and ra.
    assign sec_addr = ((op == OP_ADD) || (op == OP_NAND)) ? get_rc(inst) : ra;
    assign mem_idx  = MEM_AW'(rb_val + imm_s);

    assign out_load_ready = (state == ST_IDLE) || (state == ST_HALT);
    assign out_halted     = (state == ST_HALT);
    assign out_pc         = pc;
    assign out_retired    = retired;

    // A load has priority over run when both arrive while stopped.
    assign start = out_load_ready && in_run && !in_load_valid;

    myrisc16_regfile u_regfile (
        .clk       (in_clock),
        .rst_n     (in_reset_n),
        .clear     (start),
        .rd_addr_a (rb),
        .rd_addr_b (sec_addr),
        .rd_data_a (rb_val),
        .rd_data_b (sec_val),
        .wr_en     (rf_we),
        .wr_addr   (ra),
        .wr_data   (rf_wdata)
    );

    // State register.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) state <= ST_IDLE;
        else             state <= state_next;
    end

    // Next-state logic: stopped states wait for run, otherwise alternate fetch/execute.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HALT: if (start) state_next = ST_FETCH;
            ST_FETCH:         state_next = ST_EXEC;
            ST_EXEC:          state_next = is_halt(inst) ? ST_HALT : ST_FETCH;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Execute-stage register writeback and the shared memory write port.
    always_comb begin
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_we    = 1'b0;
        mem_waddr = in_load_addr;
        mem_wdata = in_load_data;
        if (out_load_ready && in_load_valid) begin
            mem_we = 1'b1;
        end else if (exec && (op == OP_SW)) begin
            mem_we    = 1'b1;
            mem_waddr = mem_idx;
            mem_wdata = sec_val;
        end
        if (exec) begin
            case (op)
                OP_ADD:  begin rf_we = 1'b1; rf_wdata = rb_val + sec_val;    end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = rb_val + imm_s;      end
                OP_NAND: begin rf_we = 1'b1; rf_wdata = ~(rb_val & sec_val); end
                OP_LUI:  begin rf_we = 1'b1; rf_wdata = get_lui(inst);       end
                OP_LW:   begin rf_we = 1'b1; rf_wdata = mem[mem_idx];        end
                OP_JALR: begin rf_we = !is_halt(inst); rf_wdata = pc;        end
                default: begin rf_we = 1'b0; rf_wdata = '0;                  end
            endcase
        end
    end

    // Program memory has no reset so the loaded image survives a reset.
    always_ff @(posedge in_clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Program counter, instruction register, LED register and retire counter.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            pc      <= '0;
            inst    <= '0;
            retired <= '0;
            out_led <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                ST_FETCH: begin
                    inst <= mem[pc[MEM_AW-1:0]];
                    pc   <= pc + 16'd1;
                end
                ST_EXEC: begin
                    retired <= retired + 16'd1;
                    if ((op == OP_BEQ) && (sec_val == rb_val)) begin
                        pc <= pc + imm_s;
                    end else if ((op == OP_JALR) && !is_halt(inst)) begin
                        pc <= rb_val;
                    end
                    if ((op == OP_SW) && (mem_idx == LED_IDX)) begin
                        out_led <= sec_val[LED_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myrisc16_core.sv
// Scoreboard testbench for myrisc16_core: directed programs plus random
// programs checked against an instruction-level interpreter.
module tb_myrisc16_core;

    localparam int DEPTH     = 16;
    localparam int MAX_STEPS = 300;

    typedef struct packed {
        logic [7:0]  led;
        logic [15:0] retired;
        logic [15:0] pc;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        load_valid = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        halted;
    logic [7:0]  led;
    logic [15:0] pc;
    logic [15:0] retired;

    logic        run8 = 1'b0;
    logic        load_valid8 = 1'b0;
    logic [2:0]  load_addr8 = '0;
    logic [15:0] load_data8 = '0;
    logic        load_ready8;
    logic        halted8;
    logic [7:0]  led8;
    logic [15:0] pc8;
    logic [15:0] retired8;

    int errors = 0;
    int checks = 0;
    int halts_seen = 0;

    expect_t     sb_q[$];
    expect_t     sb_e;
    logic        prev_halted = 1'b0;

    logic [15:0] image [DEPTH];
    logic [15:0] image8 [8];
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_reg [8];
    logic [7:0]  model_led;
    logic [7:0]  committed_led = 8'h00;
    logic [15:0] model_pc;
    logic [15:0] model_retired;
    logic        model_halted;
    int          model_steps;

    myrisc16_core #(.MEM_AW(4), .LED_W(8), .LED_ADDR(15)) dut (
        .in_clock       (clk),
        .in_reset_n     (rst_n),
        .in_run         (run),
        .in_load_valid  (load_valid),
        .in_load_addr   (load_addr),
        .in_load_data   (load_data),
        .out_load_ready (load_ready),
        .out_halted     (halted),
        .out_led        (led),
        .out_pc         (pc),
        .out_retired    (retired)
    );

    myrisc16_core #(.MEM_AW(3), .LED_W(8), .LED_ADDR(7)) dut8 (
        .in_clock       (clk),
        .in_reset_n     (rst_n),
        .in_run         (run8),
        .in_load_valid  (load_valid8),
        .in_load_addr   (load_addr8),
        .in_load_data   (load_data8),
        .out_load_ready (load_ready8),
        .out_halted     (halted8),
        .out_led        (led8),
        .out_pc         (pc8),
        .out_retired    (retired8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Monitor: every rising edge of halted retires one scoreboard entry.
    always @(negedge clk) begin
        if (halted && !prev_halted) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_halt: got halt at pc 0x%04h, expected no halt", pc);
            end else begin
                sb_e = sb_q.pop_front();
                checkOutput("sb_led", {8'h00, led}, {8'h00, sb_e.led});
                checkOutput("sb_retired", retired, sb_e.retired);
                checkOutput("sb_pc", pc, sb_e.pc);
            end
            halts_seen++;
        end
        prev_halted = halted;
    end

    // Instruction-level interpreter working from the ISA rules.
    task automatic modelRun();
        logic [15:0] w, a, b, c, s, addr, res, ret;
        int wi, op, ra, rb, rc, lo, idx;
        logic wen;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = image[i];
        for (int i = 0; i < 8; i++) model_reg[i] = 16'h0000;
        model_led = committed_led;
        model_pc = 16'h0000;
        model_retired = 16'h0000;
        model_halted = 1'b0;
        model_steps = 0;
        while (!model_halted && model_steps < MAX_STEPS) begin
            w = model_mem[int'(model_pc) % DEPTH];
            model_pc = model_pc + 16'd1;
            wi = int'(w);
            op = wi / 8192;
            ra = (wi / 1024) % 8;
            rb = (wi / 128) % 8;
            rc = wi % 8;
            lo = wi % 128;
            s = 16'((lo >= 64) ? lo - 128 : lo);
            a = model_reg[ra];
            b = model_reg[rb];
            c = model_reg[rc];
            addr = b + s;
            idx = int'(addr) % DEPTH;
            wen = 1'b0;
            res = 16'h0000;
            case (op)
                0: begin wen = 1'b1; res = b + c; end
                1: begin wen = 1'b1; res = b + s; end
                2: begin wen = 1'b1; res = ~(b & c); end
                3: begin wen = 1'b1; res = 16'((wi % 1024) * 64); end
                4: begin
                    model_mem[idx] = a;
                    if (idx == DEPTH - 1) model_led = a[7:0];
                end
                5: begin wen = 1'b1; res = model_mem[idx]; end
                6: if (a == b) model_pc = model_pc + s;
                default: begin
                    if (lo == 0) begin
                        ret = model_pc;
                        model_pc = b;
                        wen = 1'b1;
                        res = ret;
                    end else begin
                        model_halted = 1'b1;
                    end
                end
            endcase
            if (wen && ra != 0) model_reg[ra] = res;
            model_retired = model_retired + 16'd1;
            model_steps++;
        end
    endtask

    task automatic makeRandomImage();
        int r;
        logic [15:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 9);
            w = 16'($urandom);
            if (r <= 6) begin
                w[15:13] = 3'(r);
            end else if (r == 7) begin
                w[15:13] = 3'd7;
                w[6:0] = 7'd0;
            end else begin
                w[15:13] = 3'd7;
                if (w[6:0] == 7'd0) w[6:0] = 7'd1;
            end
            image[i] = w;
        end
    endtask

    task automatic fillImage(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
        for (int i = 0; i < DEPTH; i++) image[i] = 16'hE001;
        image[0] = w0; image[1] = w1; image[2] = w2;
        image[3] = w3; image[4] = w4; image[5] = w5;
    endtask

    task automatic loadImage();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_addr = 4'(i);
            load_data = image[i];
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulseRun();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic applyStimulus(input expect_t e);
        loadImage();
        sb_q.push_back(e);
        pulseRun();
    endtask

    task automatic waitHalt(input int start, input int budget, input string name);
        int n;
        expect_t junk;
        n = 0;
        while (halts_seen == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (halts_seen == start) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no halt after %0d cycles, expected halt", name, budget);
            if (sb_q.size() > 0) junk = sb_q.pop_front();
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int tries;
        int n;
        expect_t e;

        $display("[TB] starting myrisc16_core bench");
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pc", pc, 16'h0000);
        checkOutput("reset_retired", retired, 16'h0000);
        checkOutput("reset_led", {8'h00, led}, 16'h0000);
        checkOutput("reset_halted", {15'd0, halted}, 16'd0);
        checkOutput("reset_load_ready", {15'd0, load_ready}, 16'd1);
        rst_n = 1'b1;

        // Counter program with exact halt timing.
        fillImage(16'h2481, 16'h847F, 16'hE001, 16'hE001, 16'hE001, 16'hE001);
        start = halts_seen;
        applyStimulus('{led: 8'h01, retired: 16'd3, pc: 16'd3});
        repeat (5) @(posedge clk);
        #1 checkOutput("t1_halted_edge5", {15'd0, halted}, 16'd0);
        @(posedge clk);
        #1 checkOutput("t1_halted_edge6", {15'd0, halted}, 16'd1);
        waitHalt(start, 20, "t1_halt");

        // Load and run together in HALT: load wins, then run alone restarts.
        load_valid = 1'b1; load_addr = 4'd2; load_data = 16'h0000; run = 1'b1;
        @(posedge clk);
        #1 checkOutput("t5_still_halted", {15'd0, halted}, 16'd1);
        checkOutput("t5_pc_unchanged", pc, 16'd3);
        @(negedge clk);
        load_valid = 1'b0;
        start = halts_seen;
        sb_q.push_back('{led: 8'h01, retired: 16'd4, pc: 16'd4});
        @(posedge clk);
        #1 checkOutput("t5_restart_halted", {15'd0, halted}, 16'd0);
        checkOutput("t5_restart_pc", pc, 16'd0);
        checkOutput("t5_restart_retired", retired, 16'd0);
        @(negedge clk);
        run = 1'b0;
        waitHalt(start, 30, "t5_halt");

        // LUI + NAND.
        fillImage(16'h6BFF, 16'h4D02, 16'h8C7F, 16'hE001, 16'hE001, 16'hE001);
        start = halts_seen;
        applyStimulus('{led: 8'h3F, retired: 16'd4, pc: 16'd4});
        waitHalt(start, 30, "t2_halt");

        // JALR skips words 2 and 3, which would otherwise store 4 to the LEDs.
        fillImage(16'h2804, 16'hFD00, 16'h887F, 16'h887F, 16'h9C7F, 16'hE001);
        start = halts_seen;
        applyStimulus('{led: 8'h02, retired: 16'd4, pc: 16'd6});
        waitHalt(start, 30, "t3_halt");

        // Tight BEQ loop, ignored load while busy, reset mid-EXEC.
        fillImage(16'hC07F, 16'hE001, 16'hE001, 16'hE001, 16'hE001, 16'hE001);
        loadImage();
        pulseRun();
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1 checkOutput("t4_loop_pc", pc, (i % 2 == 1) ? 16'd1 : 16'd0);
            if (i == 10) begin
                load_valid = 1'b1; load_addr = 4'd0; load_data = 16'hE001;
                checkOutput("t4_busy_load_ready", {15'd0, load_ready}, 16'd0);
            end
            if (i == 12) load_valid = 1'b0;
        end
        @(posedge clk);
        #1 checkOutput("t4_exec_pc", pc, 16'd1);
        rst_n = 1'b0;
        #1 checkOutput("t4_rst_pc", pc, 16'd0);
        checkOutput("t4_rst_led", {8'h00, led}, 16'h0000);
        checkOutput("t4_rst_load_ready", {15'd0, load_ready}, 16'd1);
        committed_led = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseRun();
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1 checkOutput("t4_rerun_pc", pc, (i % 2 == 1) ? 16'd1 : 16'd0);
            checkOutput("t4_rerun_halted", {15'd0, halted}, 16'd0);
        end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Random programs against the interpreter.
        for (int t = 0; t < 25; t++) begin
            tries = 0;
            do begin
                makeRandomImage();
                modelRun();
                tries++;
            end while (!model_halted && tries < 50);
            if (!model_halted) begin
                for (int i = 0; i < DEPTH; i++) image[i] = 16'hE001;
                modelRun();
            end
            committed_led = model_led;
            e.led = model_led;
            e.retired = model_retired;
            e.pc = model_pc;
            start = halts_seen;
            applyStimulus(e);
            waitHalt(start, model_steps * 2 + 20, "rand_halt");
        end

        // Address wrap on the 8-word instance.
        image8[0] = 16'h240F; image8[1] = 16'h8480; image8[2] = 16'h2808; image8[3] = 16'hAD00;
        image8[4] = 16'h2D81; image8[5] = 16'h8C7F; image8[6] = 16'hE001; image8[7] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_valid8 = 1'b1; load_addr8 = 3'(i); load_data8 = image8[i];
        end
        @(negedge clk);
        load_valid8 = 1'b0;
        run8 = 1'b1;
        @(negedge clk);
        run8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("w_led_before_sw", {8'h00, led8}, 16'h0000);
        @(posedge clk);
        #1 checkOutput("w_led_alias_sw", {8'h00, led8}, 16'h000F);
        n = 0;
        while (!halted8 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("w_halted", {15'd0, halted8}, 16'd1);
        checkOutput("w_led_lw_alias", {8'h00, led8}, 16'h0010);
        checkOutput("w_retired", retired8, 16'd7);
        checkOutput("w_pc", pc8, 16'd7);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
